// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the pipeline memory stage and
// one external requester. At most one access is outstanding, and reads have a fixed latency.
module dmem_arbiter #(
   parameter int WIDTH   = 32,
   parameter int MEM_LAT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             MemWriteM,
   input  logic             MemtoRegM,
   input  logic [WIDTH-1:0] ALUOutM,
   input  logic [WIDTH-1:0] WriteDataM,
   output logic             StallMem,
   output logic [WIDTH-1:0] ReadDataM,
   input  logic             ext_req,
   input  logic             ext_we,
   input  logic [WIDTH-1:0] ext_addr,
   input  logic [WIDTH-1:0] ext_wdata,
   output logic             ext_gnt,
   output logic             ext_rvalid,
   output logic [WIDTH-1:0] ext_rdata,
   output logic             mem_en,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata
);

   localparam int CW = $clog2(MEM_LAT + 1);
   localparam logic [CW-1:0] LAT_INIT = CW'(MEM_LAT - 1);

   typedef enum logic [1:0] {IDLE, CPU_RD, EXT_RD} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    lat_cnt;
   logic             last_ext;
   logic [WIDTH-1:0] rdata_q, ext_q;

   logic cpu_req, idle, cpu_win, cpu_gnt, ext_win;
   logic cpu_rd_done, ext_rd_done, cpu_done, issue_rd;

   assign cpu_req     = MemWriteM | MemtoRegM;
   assign idle        = (state == IDLE);
   // On a tie, the requester that lost the previous arbitration wins.
   assign cpu_win     = cpu_req & (~ext_req | last_ext);
   assign ext_win     = ext_req & ~cpu_win;
   assign cpu_gnt     = idle & cpu_win;
   assign cpu_rd_done = (state == CPU_RD) && (lat_cnt == '0);
   assign ext_rd_done = (state == EXT_RD) && (lat_cnt == '0);
   assign cpu_done    = (cpu_gnt & MemWriteM) | cpu_rd_done;
   assign issue_rd    = (cpu_gnt & ~MemWriteM) | (idle & ext_win & ~ext_we);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (cpu_gnt && !MemWriteM)               state_nxt = CPU_RD;
            else if (idle && ext_win && !ext_we)     state_nxt = EXT_RD;
         end
         CPU_RD:  if (lat_cnt == '0) state_nxt = IDLE;
         EXT_RD:  if (lat_cnt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      StallMem   = 1'b0;
      ReadDataM  = '0;
      ext_gnt    = 1'b0;
      ext_rvalid = 1'b0;
      ext_rdata  = '0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      if (!reset) begin
         StallMem   = cpu_req & ~cpu_done;
         ReadDataM  = cpu_rd_done ? mem_rdata : rdata_q;
         ext_gnt    = idle & ext_win;
         ext_rvalid = ext_rd_done;
         ext_rdata  = ext_rd_done ? mem_rdata : ext_q;
         mem_en     = cpu_gnt | (idle & ext_win);
         // Address and data are zeroed when no access issues, so the bus stays quiet.
         if (cpu_gnt) begin
            mem_we    = MemWriteM;
            mem_addr  = ALUOutM;
            mem_wdata = MemWriteM ? WriteDataM : '0;
         end else if (idle && ext_win) begin
            mem_we    = ext_we;
            mem_addr  = ext_addr;
            mem_wdata = ext_we ? ext_wdata : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lat_cnt  <= '0;
         last_ext <= 1'b1;
         rdata_q  <= '0;
         ext_q    <= '0;
      end else begin
         if (idle && (cpu_win || ext_win)) last_ext <= ext_win;
         if (issue_rd)                     lat_cnt  <= LAT_INIT;
         else if (!idle && lat_cnt != '0)  lat_cnt  <= lat_cnt - CW'(1);
         if (cpu_rd_done)                  rdata_q  <= mem_rdata;
         if (ext_rd_done)                  ext_q    <= mem_rdata;
      end
   end

endmodule
